tdc_accum: RTL and testbench
============================

TDC_ACCUM -- requirements
Module: tdc_accum

Interface
REQ-001 The block SHALL have parameter IN_W, default 12, TDC code width.
REQ-002 The block SHALL have parameter SUM_W, default 20, accumulated sum width; IN_W+8 <= SUM_W.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port en  input  1  level; 1 = run accumulation windows, 0 = stop/abort.
REQ-006 The block SHALL have port in_valid  input  1  in_code qualifier, one sample per cycle.
REQ-007 The block SHALL have port in_code  input  IN_W  unsigned TDC code.
REQ-008 The block SHALL have port win_sel  input  3  window length N = 2^(win_sel+1), i.e. 2..256 samples.
REQ-009 The block SHALL have port sum_out  output  SUM_W  registered sum of last completed window.
REQ-010 The block SHALL have port dval  output  1  registered one-cycle pulse marking a new sum_out.
REQ-011 The block SHALL have port busy  output  1  high while in ACCUM or DONE.

Function
REQ-012 The FSM SHALL have states IDLE, ACCUM, DONE.
REQ-013 IDLE->ACCUM when en=1; acc and sample counter cleared; win_sel latched into n_lat on this transition only.
REQ-014 In ACCUM, each cycle with in_valid=1 SHALL add zero-extended in_code to acc and increment cnt.
REQ-015 When the accepted sample makes cnt reach n_lat, ACCUM->DONE on the next edge.
REQ-016 In DONE (exactly one cycle), sum_out SHALL load acc and dval SHALL be 1 in that same cycle; dval is 0 in all other states.
REQ-017 Latency: dval high exactly 2 cycles after the edge that samples the Nth valid input.
REQ-018 A valid sample during the DONE cycle SHALL become sample 1 of the next window (acc := in_code, cnt := 1); it is never dropped.
REQ-019 DONE->ACCUM if en=1, re-latching win_sel; DONE->IDLE if en=0, with the DONE-cycle sample discarded.
REQ-020 en=0 during ACCUM SHALL abort: partial acc discarded, no dval, sum_out unchanged, ->IDLE next edge.
REQ-021 in_valid in IDLE SHALL be ignored.
REQ-022 win_sel changes during a window SHALL not affect that window.
REQ-023 sum_out SHALL hold its value between dval pulses.
REQ-024 Width rule: max sum 256*(2^IN_W-1) fits SUM_W, so no saturation logic; acc is SUM_W wide, cnt is 9 bits.
REQ-025 The dval pulse width SHALL be exactly one cycle, glitch-free from a flop, suitable for edge use downstream.

Reset
REQ-026 rst=1 SHALL force state=IDLE, acc=0, cnt=0, n_lat=0, sum_out=0, dval=0, busy=0 on the next edge, overriding all other inputs.
REQ-027 Reset mid-window or during DONE SHALL suppress that dval and discard the partial sum.

Structure
REQ-028 Shared package tdc_pkg SHALL hold IN_W/SUM_W defaults, the FSM state enum and the window-length decode function.
REQ-029 The block SHALL be a single module with no sub-module; the window counter is inline.

Verification
REQ-030 Run win_sel=0, en=1, codes 100,200 on consecutive cycles -> one dval, sum_out=300, dval 2 cycles after the code-200 edge.
REQ-031 Run win_sel=7, 256 samples of 4095 -> sum_out=1048320, no wrap; next window starts clean.
REQ-032 Run win_sel=1 with in_valid gaps: codes 1,2,3,4 and idle cycles between them -> sum_out=10.
REQ-033 Run back-to-back windows with win_sel=0 and continuous valid codes 5,6,7,8 (7 falls in the DONE cycle) -> dvals with sums 11 then 15, no sample lost.
REQ-034 Drop en after 3 of 4 samples -> no dval, sum_out keeps the previous value, busy=0 within 1 cycle.
REQ-035 Assert rst one cycle before a pending DONE -> no dval, sum_out=0, state IDLE.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC window accumulator: default widths,
// FSM state encoding and the win_sel -> window-length decode.
package tdc_pkg;

  localparam int IN_W_DEF  = 12;
  localparam int SUM_W_DEF = 20;
  // 9 bits holds the largest window length (256).
  localparam int CNT_W     = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } tdc_state_t;

  // Window length N = 2^(win_sel+1), giving 2..256 samples.
  function automatic logic [CNT_W-1:0] win_len(input logic [2:0] ws);
    win_len = CNT_W'(2) << ws;
  endfunction

endpackage

// File: rtl/tdc_accum.sv
// TDC code accumulator: sums a window of 2..256 valid codes and presents
// the total on sum_out with a one-cycle dval pulse. A sample arriving in
// the DONE cycle opens the next window, so back-to-back windows lose nothing.
module tdc_accum
  import tdc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_code,
  input  logic [2:0]       win_sel,
  output logic [SUM_W-1:0] sum_out,
  output logic             dval,
  output logic             busy
);

  tdc_state_t       state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_lat_q, n_lat_d;
  logic [SUM_W-1:0] sum_out_q, sum_out_d;
  logic             dval_q, dval_d;
  logic             busy_q, busy_d;

  logic [SUM_W-1:0] code_ext;
  logic [CNT_W-1:0] cnt_inc;

  assign code_ext = {{(SUM_W-IN_W){1'b0}}, in_code};
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Next-state / datapath: window start, accumulate, publish, abort.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    n_lat_d   = n_lat_q;
    sum_out_d = sum_out_q;
    dval_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // in_valid is ignored here; the window opens on the next cycle.
        if (en) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          n_lat_d = win_len(win_sel);
        end
      end
      ACCUM: begin
        if (!en) begin
          // Abort: partial sum dropped, sum_out untouched.
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (in_valid) begin
          acc_d = acc_q + code_ext;
          cnt_d = cnt_inc;
          if (cnt_inc == n_lat_q) state_d = DONE;
        end
      end
      DONE: begin
        // acc_q holds the finished window; publish it regardless of en.
        sum_out_d = acc_q;
        dval_d    = 1'b1;
        if (en) begin
          // Any sample in this cycle becomes sample 1 of the next window.
          state_d = ACCUM;
          n_lat_d = win_len(win_sel);
          acc_d   = in_valid ? code_ext : '0;
          cnt_d   = in_valid ? CNT_W'(1) : '0;
        end else begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      n_lat_q   <= '0;
      sum_out_q <= '0;
      dval_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      n_lat_q   <= n_lat_d;
      sum_out_q <= sum_out_d;
      dval_q    <= dval_d;
      busy_q    <= busy_d;
    end
  end

  assign sum_out = sum_out_q;
  assign dval    = dval_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_tdc_accum.sv
// Self-checking bench for tdc_accum: directed scenarios plus randomized
// traffic compared against a sample-queue reference model.
module tb_tdc_accum;

  localparam int IN_W  = 12;
  localparam int SUM_W = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             in_valid;
  logic [IN_W-1:0]  in_code;
  logic [2:0]       win_sel;
  logic [SUM_W-1:0] sum_out;
  logic             dval;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: samples of the open window, its length, and a
  // finished-window total waiting to be published on the following edge.
  int     m_q[$];
  int     m_n;
  bit     m_open;
  bit     m_pend;
  longint m_pend_sum;
  longint m_sum;
  bit     m_dval;
  bit     m_busy;

  tdc_accum #(.IN_W(IN_W), .SUM_W(SUM_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .in_code  (in_code),
    .win_sel  (win_sel),
    .sum_out  (sum_out),
    .dval     (dval),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint qsum();
    longint s = 0;
    foreach (m_q[i]) s += m_q[i];
    return s;
  endfunction

  // Model update for one rising edge given the inputs sampled there.
  task automatic model_edge(input bit r, input bit e, input bit v, input int c, input int w);
    if (r) begin
      m_open = 0; m_pend = 0; m_q.delete(); m_n = 0;
      m_sum = 0; m_dval = 0;
    end else begin
      m_dval = 0;
      if (m_pend) begin
        m_sum  = m_pend_sum;
        m_dval = 1;
        m_pend = 0;
        m_q.delete();
        if (e) begin
          m_open = 1;
          m_n    = 2 << w;
          if (v) m_q.push_back(c);
        end else begin
          m_open = 0;
        end
      end else if (m_open) begin
        if (!e) begin
          m_open = 0;
          m_q.delete();
        end else if (v) begin
          m_q.push_back(c);
          if (m_q.size() == m_n) begin
            m_pend_sum = qsum();
            m_pend     = 1;
            m_open     = 0;
            m_q.delete();
          end
        end
      end else if (e) begin
        m_open = 1;
        m_n    = 2 << w;
        m_q.delete();
      end
    end
    m_busy = m_open || m_pend;
  endtask

  // Apply inputs for one cycle, advance the model and compare all outputs.
  task automatic step(input bit r, input bit e, input bit v, input int c, input int w);
    rst      = r;
    en       = e;
    in_valid = v;
    in_code  = IN_W'(c);
    win_sel  = 3'(w);
    @(posedge clk);
    model_edge(r, e, v, c, w);
    #1;
    chk("sum_out", 32'(sum_out), 32'(m_sum));
    chk("dval", 32'(dval), 32'(m_dval));
    chk("busy", 32'(busy), 32'(m_busy));
  endtask

  initial begin
    m_open = 0; m_pend = 0; m_n = 0; m_sum = 0; m_dval = 0; m_busy = 0; m_pend_sum = 0;

    // Reset state
    step(1, 1, 1, 77, 3);
    step(1, 0, 0, 0, 0);
    chk("rst_sum", 32'(sum_out), 0);
    chk("rst_busy", 32'(busy), 0);

    // Two-sample window: 100+200, dval one edge after the DONE edge
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 100, 0);
    step(0, 1, 1, 200, 0);
    chk("w2_dval_early", 32'(dval), 0);
    step(0, 0, 0, 0, 0);
    chk("w2_dval", 32'(dval), 1);
    chk("w2_sum", 32'(sum_out), 300);
    step(0, 0, 1, 55, 0);
    chk("w2_dval_once", 32'(dval), 0);
    chk("w2_hold", 32'(sum_out), 300);

    // Full-scale 256-sample window, then a clean small window
    step(0, 1, 0, 0, 7);
    for (int i = 0; i < 256; i++) step(0, 1, 1, 4095, (i % 2) ? 0 : 7);
    step(0, 0, 0, 0, 0);
    chk("w256_sum", 32'(sum_out), 1048320);
    chk("w256_dval", 32'(dval), 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 2, 0);
    step(0, 0, 0, 0, 0);
    chk("clean_sum", 32'(sum_out), 3);

    // Four-sample window with gaps, win_sel changing mid-window
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 9, 0);
    step(0, 1, 1, 2, 5);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 2);
    step(0, 1, 1, 3, 0);
    step(0, 1, 1, 4, 0);
    step(0, 0, 0, 0, 0);
    chk("gap_sum", 32'(sum_out), 10);

    // Back-to-back windows, 7 lands in the DONE cycle
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 5, 0);
    step(0, 1, 1, 6, 0);
    step(0, 1, 1, 7, 0);
    chk("b2b_sum1", 32'(sum_out), 11);
    chk("b2b_dval1", 32'(dval), 1);
    step(0, 1, 1, 8, 0);
    step(0, 0, 0, 0, 0);
    chk("b2b_sum2", 32'(sum_out), 15);
    chk("b2b_dval2", 32'(dval), 1);

    // Abort after 3 of 4 samples
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 10, 1);
    step(0, 1, 1, 11, 1);
    step(0, 1, 1, 12, 1);
    step(0, 0, 1, 13, 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sum", 32'(sum_out), 15);
    step(0, 0, 0, 0, 1);
    chk("abort_nodval", 32'(dval), 0);

    // Reset on the edge that would complete the window
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 9, 0);
    step(1, 1, 1, 10, 0);
    step(0, 0, 0, 0, 0);
    chk("rstdone_dval", 32'(dval), 0);
    chk("rstdone_sum", 32'(sum_out), 0);
    chk("rstdone_busy", 32'(busy), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit r, e, v;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 19) != 0);
      v = ($urandom_range(0, 9) < 7);
      step(r, e, v, int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
